// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: shared FSM state encoding, default sizing constants and the
// parity helper for the uart_txq transmit queue.
// Optional feature macro: UART_TXQ_PARITY_EN (adds an even-parity bit).
package uart_txq_pkg;

  // 100 MHz system clock at 115200 baud
  localparam int unsigned CLK_DIV_DEF = 868;
  localparam int unsigned DEPTH_DEF   = 16;

  // Baud down-counter width covers the full legal CLK_DIV range
  localparam int unsigned BAUD_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TXQ_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TXQ_PARITY_EN
  // Even parity: the bit that makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/txq_fifo.sv
// txq_fifo: synchronous FIFO for the UART transmit queue. Occupancy is kept as
// an explicit counter so level/full/empty are all plain register decodes.
// The read port is combinational so the consumer can pop and capture the head
// byte on the same edge.
module txq_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_next;

  // Qualify requests so overflow/underflow can never corrupt the pointers
  assign w_push = push & ~r_full;
  assign w_pop  = pop & (r_level != '0);

  // Occupancy next-state: simultaneous push and pop leave it unchanged
  always_comb begin
    w_level_next = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + 1'b1;
      2'b01:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/uart_txq.sv
// uart_txq: byte-wide transmit FIFO feeding an 8N1 UART serializer.
// Optional feature macro: UART_TXQ_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1 framing).
module uart_txq
  import uart_txq_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [7:0]              wr_data,
  output logic                    tx,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam logic [BAUD_CNT_W-1:0] DIV_RELOAD = BAUD_CNT_W'(CLK_DIV - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BAUD_CNT_W-1:0]   r_baud_cnt;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_shift;
  logic                    r_tx;
`ifdef UART_TXQ_PARITY_EN
  logic                    r_parity;
`endif

  logic                    w_tick;
  logic                    w_pop;
  logic                    w_reload;
  logic                    w_tx_next;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [7:0]              w_fifo_dout;
  logic [$clog2(DEPTH):0]  w_level;

  txq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_valid),
    .din    (wr_data),
    .full   (w_fifo_full),
    .pop    (w_pop),
    .dout   (w_fifo_dout),
    .empty  (w_fifo_empty),
    .level  (w_level)
  );

  // End of the current bit period
  assign w_tick = (r_baud_cnt == '0);

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: each non-idle state advances when its bit period expires
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_TXQ_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TXQ_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Back-to-back frames: no idle bit when another byte is queued
        if (w_tick) begin
          w_state_next = w_fifo_empty ? ST_IDLE : ST_START;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop, counter reload and the value tx takes next edge
  always_comb begin
    w_pop     = 1'b0;
    w_reload  = 1'b0;
    w_tx_next = r_tx;
    unique case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_reload  = 1'b1;
          w_tx_next = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_reload  = 1'b1;
          w_tx_next = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_reload = 1'b1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TXQ_PARITY_EN
            w_tx_next = r_parity;
`else
            w_tx_next = 1'b1;
`endif
          end else begin
            // r_shift[1] becomes the LSB after this edge's shift
            w_tx_next = r_shift[1];
          end
        end
      end
`ifdef UART_TXQ_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_reload  = 1'b1;
          w_tx_next = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_reload = 1'b1;
          if (!w_fifo_empty) begin
            w_pop     = 1'b1;
            w_tx_next = 1'b0;
          end else begin
            w_tx_next = 1'b1;
          end
        end
      end
      default: begin
        w_tx_next = 1'b1;
      end
    endcase
  end

  // Baud down-counter: reloaded at the start of every bit period
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_baud_cnt <= '0;
    end else if (w_reload) begin
      r_baud_cnt <= DIV_RELOAD;
    end else if ((r_state != ST_IDLE) && !w_tick) begin
      r_baud_cnt <= r_baud_cnt - 1'b1;
    end
  end

  // Shift register and bit index: load on pop, shift right per data bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else if (w_pop) begin
      r_shift   <= w_fifo_dout;
      r_bit_idx <= '0;
    end else if ((r_state == ST_DATA) && w_tick && (r_bit_idx != 3'd7)) begin
      r_shift   <= {1'b0, r_shift[7:1]};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

`ifdef UART_TXQ_PARITY_EN
  // Parity captured alongside the byte so it is stable through the frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= even_parity(w_fifo_dout);
    end
  end
`endif

  // Serial line flop: tx never comes straight from combinational logic
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
    end
  end

  assign tx       = r_tx;
  assign wr_ready = ~w_fifo_full;
  assign level    = w_level;
  assign busy     = (r_state != ST_IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: directed bench for uart_txq at CLK_DIV=4, DEPTH=16.
// Honours UART_TXQ_PARITY_EN for frame length and the parity scenarios.
module tb_uart_txq;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 16;
`ifdef UART_TXQ_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       resetn;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] q4 [18];
  logic [7:0] q6 [40];

  uart_txq #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a start bit; on return we sit on its first sample
  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " start_seen"}, {31'd0, tx}, 32'd0);
  endtask

  // Check every sample of one frame, starting at the first start-bit sample
  task automatic frame(input logic [7:0] b, input string tag);
    logic [NB-1:0] bits;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
`ifdef UART_TXQ_PARITY_EN
    bits[9]  = ^b;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    for (int k = 0; k < NB; k++) begin
      for (int s = 0; s < int'(CLK_DIV); s++) begin
        check($sformatf("%s bit%0d s%0d", tag, k, s), {31'd0, tx}, {31'd0, bits[k]});
        @(negedge clk);
      end
    end
    $display("frame %s byte 0x%02h done at %0t", tag, b, $time);
  endtask

  // Flow-controlled single-byte push; returns one clock after acceptance
  task automatic push_byte(input logic [7:0] b, input string tag);
    int   n = 0;
    logic acc;
    wr_data  = b;
    wr_valid = 1'b1;
    do begin
      acc = wr_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 200);
    wr_valid = 1'b0;
    check({tag, " accepted"}, {31'd0, acc}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 18; i++) q4[i] = 8'(i * 29 + 3);
    for (int i = 0; i < 40; i++) q6[i] = 8'(i * 37 + 11);

    // ---- reset state ----
    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst tx", {31'd0, tx}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst level", {27'd0, level}, 32'd0);
    check("rst wr_ready", {31'd0, wr_ready}, 32'd1);
    resetn = 1'b1;

    // ---- single byte 0x55 into idle block ----
    wr_data  = 8'h55;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("t55 level", {27'd0, level}, 32'd1);
    check("t55 busy", {31'd0, busy}, 32'd1);
    check("t55 tx_before", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("t55 start_latency", {31'd0, tx}, 32'd0);
    frame(8'h55, "t55");
    check("t55 busy_end", {31'd0, busy}, 32'd0);
    check("t55 tx_idle", {31'd0, tx}, 32'd1);

    // ---- back-to-back 0xA3, 0x0F ----
    wr_data  = 8'hA3;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_data  = 8'h0F;
    @(negedge clk);
    wr_valid = 1'b0;
    check("b2b level_pushpop", {27'd0, level}, 32'd1);
    check("b2b start_latency", {31'd0, tx}, 32'd0);
    frame(8'hA3, "b2b0");
    frame(8'h0F, "b2b1");
    check("b2b busy_end", {31'd0, busy}, 32'd0);

    // ---- fill to full during a frame, 17th write stalls ----
    wr_data  = q4[0];
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    fork
      begin
        wait_start("full");
        for (int i = 0; i < 18; i++) frame(q4[i], $sformatf("full%0d", i));
      end
      begin
        int n;
        for (int i = 1; i <= 16; i++) push_byte(q4[i], $sformatf("fill%0d", i));
        check("full level16", {27'd0, level}, 32'd16);
        check("full wr_ready0", {31'd0, wr_ready}, 32'd0);
        wr_data  = q4[17];
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("full stalled", {31'd0, (n > 20)}, 32'd1);
        check("full level_after_pop", {27'd0, level}, 32'd15);
        @(negedge clk);
        wr_valid = 1'b0;
        check("full level_refill", {27'd0, level}, 32'd16);
      end
    join
    check("full busy_end", {31'd0, busy}, 32'd0);

    // ---- asynchronous reset mid-frame ----
    wr_data  = 8'h5A;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_data  = 8'h11;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_start("rst");
    repeat (12) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst tx", {31'd0, tx}, 32'd1);
    check("arst level", {27'd0, level}, 32'd0);
    check("arst busy", {31'd0, busy}, 32'd0);
    check("arst wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    check("arst tx_hold", {31'd0, tx}, 32'd1);
    resetn   = 1'b1;
    wr_data  = 8'hC4;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("arst first_accept", {27'd0, level}, 32'd1);
    @(negedge clk);
    check("arst start_latency", {31'd0, tx}, 32'd0);
    frame(8'hC4, "arst");
    check("arst busy_end", {31'd0, busy}, 32'd0);

    // ---- push+pop at level 5, then 40 bytes through the wrapping pointers ----
    fork
      begin
        wait_start("wrap");
        for (int i = 0; i < 40; i++) frame(q6[i], $sformatf("wrap%0d", i));
      end
      begin
        for (int i = 0; i < 6; i++) begin
          wr_data  = q6[i];
          wr_valid = 1'b1;
          @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (35) @(negedge clk);
        check("pp level_before", {27'd0, level}, 32'd5);
        wr_data  = q6[6];
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("pp level_same", {27'd0, level}, 32'd5);
        for (int i = 7; i < 40; i++) push_byte(q6[i], $sformatf("wrap_push%0d", i));
      end
    join
    check("wrap busy_end", {31'd0, busy}, 32'd0);
    check("wrap level_end", {27'd0, level}, 32'd0);

`ifdef UART_TXQ_PARITY_EN
    // ---- parity frames: 0x07 -> parity 1, 0x03 -> parity 0 ----
    wr_data  = 8'h07;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    check("par07 start_latency", {31'd0, tx}, 32'd0);
    frame(8'h07, "par07");
    check("par07 busy_end", {31'd0, busy}, 32'd0);
    wr_data  = 8'h03;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    check("par03 start_latency", {31'd0, tx}, 32'd0);
    frame(8'h03, "par03");
    check("par03 busy_end", {31'd0, busy}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txq.md
UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 Parameter CLK_DIV, default 868, clocks per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_valid  input  1  producer byte valid; connected to the bus-side UART register write strobe.
REQ-006 wr_ready  output  1  FIFO can accept a byte this cycle.
REQ-007 wr_data  input  8  byte to transmit.
REQ-008 tx  output  1  serial line; idle high.
REQ-009 busy  output  1  FIFO non-empty or frame in progress.
REQ-010 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-011 The byte SHALL be accepted on a rising edge only when wr_valid and wr_ready are both high; wr_data is then written at the write pointer.
REQ-012 wr_ready SHALL equal the registered "not full" state; a simultaneous pop SHALL NOT make a full FIFO accept in the same cycle.
REQ-013 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; level = writes minus reads, range 0..DEPTH.
REQ-014 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 In IDLE with FIFO non-empty, the FSM SHALL pop one byte into a shift register and enter START on the same edge; tx falls one clock after the accepting edge for a write into an empty, idle block.
REQ-016 Each of START, DATA bits, PARITY and STOP SHALL hold tx for exactly CLK_DIV clocks, timed by a down-counter reloaded with CLK_DIV-1.
REQ-017 START drives tx=0; DATA drives 8 bits LSB first using a 3-bit bit index; STOP drives tx=1.
REQ-018 At the end of STOP with FIFO non-empty, the FSM SHALL pop and go directly to START with no idle bit; otherwise it returns to IDLE.
REQ-019 A frame SHALL last 10*CLK_DIV clocks (11*CLK_DIV with parity).
REQ-020 A push and a pop in the same cycle SHALL leave level unchanged.
REQ-021 tx SHALL be driven from a flop (glitch-free).
REQ-022 busy SHALL be high when state != IDLE or level != 0.

Reset
REQ-023 On resetn low, the block SHALL immediately set tx=1, busy=0, level=0, wr_ready=1, state=IDLE, pointers and counters=0, including mid-frame; FIFO contents need not be cleared.
REQ-024 The first accept SHALL be possible on the first rising edge after resetn deasserts.

Configuration
REQ-025 The macro UART_TXQ_PARITY_EN SHALL be defined to insert a PARITY state between DATA and STOP that drives the even parity bit (XOR of the 8 data bits).
REQ-026 With the macro undefined, no PARITY state or parity logic SHALL exist, and DATA SHALL go directly to STOP.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the default CLK_DIV/DEPTH constants.
REQ-028 The FIFO SHALL be a sub-module, txq_fifo, with push/pop/full/empty/level ports. The FSM and baud counter SHALL live in uart_txq.

Verification (CLK_DIV=4, DEPTH=16)
REQ-029 Write 0x55 into idle block -> tx low 1 clk after accept; sequence 0,1,0,1,0,1,0,1,0,1 each held 4 clks; 40 clks total; busy drops after stop.
REQ-030 Write 0xA3, 0x0F back-to-back -> second start bit immediately follows first stop bit; 80 clks of continuous framing.
REQ-031 17 writes with wr_valid held high during a frame -> level reaches 16, wr_ready=0, 17th byte accepted only after a pop; all 17 bytes appear on tx in order.
REQ-032 Assert resetn low at clk 13 of a frame -> tx=1, level=0, busy=0 without waiting for clk; a new byte after release transmits cleanly.
REQ-033 With UART_TXQ_PARITY_EN, send 0x07 -> parity bit 1, frame 44 clks; send 0x03 -> parity bit 0.
REQ-034 Push and pop in the same cycle at level 5 -> level stays 5; pointer wrap checked across 40 bytes.
